// File: rtl/mod_sched_if.sv
// Command and engine-strobe bundle between the DMA channel logic (master) and the mod engine scheduler (slave).
interface mod_sched_if #(
    parameter int NENG  = 5,
    parameter int CNT_W = 24
);
    logic             cmd_valid;
    logic [23:0]      cmd_dc;
    logic             cmd_ready;
    logic             m_reset;
    logic [NENG-1:0]  m_enable;
    logic [NENG-1:0]  eng_src_getn;
    logic [NENG-1:0]  eng_dst_putn;
    logic [NENG-1:0]  eng_endn;
    logic             m_src_getn;
    logic             m_dst_putn;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [CNT_W-1:0] src_beats;
    logic [CNT_W-1:0] dst_beats;

    modport master (
        output cmd_valid, cmd_dc, eng_src_getn, eng_dst_putn, eng_endn,
        input  cmd_ready, m_reset, m_enable, m_src_getn, m_dst_putn,
               busy, done, status, src_beats, dst_beats
    );

    modport slave (
        input  cmd_valid, cmd_dc, eng_src_getn, eng_dst_putn, eng_endn,
        output cmd_ready, m_reset, m_enable, m_src_getn, m_dst_putn,
               busy, done, status, src_beats, dst_beats
    );
endinterface

// File: rtl/mod_sched.sv
// Sequences one descriptor at a time onto one mod engine; accept-to-done >= 4 cycles, cmd_ready held low while busy.
// MOD_SCHED_WDOG_EN adds a RUN-state idle watchdog that aborts a stalled engine with status 2.
module mod_sched #(
    parameter int NENG    = 5,
    parameter int SEL_LSB = 2,
    parameter int CNT_W   = 24,
    parameter int TO_W    = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    mod_sched_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4,
        ABORT = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NENG-1:0]  SEL_ONE = {{(NENG-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             hold_q;
    logic [NENG-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0] src_q, src_d;
    logic [CNT_W-1:0] dst_q, dst_d;
    logic [1:0]       status_q, status_d;

    logic [NENG-1:0]  cmd_sel;
    logic             sel_onehot;
    logic             muxing;
    logic             src_stb;
    logic             dst_stb;
    logic             end_hit;
    logic             wdog_hit;
    logic             unused_dc;

    assign cmd_sel    = bus.cmd_dc[SEL_LSB +: NENG];
    assign sel_onehot = (cmd_sel != '0) && ((cmd_sel & (cmd_sel - SEL_ONE)) == '0);
    assign unused_dc  = ^bus.cmd_dc;

    // Only the latched engine reaches the shared FIFO strobes, and only while it is enabled.
    assign muxing  = (state_q == RUN) || (state_q == FLUSH);
    assign src_stb = muxing && (|(~bus.eng_src_getn & sel_q));
    assign dst_stb = muxing && (|(~bus.eng_dst_putn & sel_q));
    assign end_hit = |(~bus.eng_endn & sel_q);

    assign bus.m_src_getn = ~src_stb;
    assign bus.m_dst_putn = ~dst_stb;
    assign bus.status     = status_q;
    assign bus.src_beats  = src_q;
    assign bus.dst_beats  = dst_q;

`ifdef MOD_SCHED_WDOG_EN
    localparam logic [TO_W-1:0] IDLE_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] IDLE_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    logic [TO_W-1:0] idle_q, idle_d;

    always_comb begin
        idle_d   = '0;
        wdog_hit = 1'b0;
        if ((state_q == RUN) && !src_stb && !dst_stb) begin
            idle_d   = idle_q + IDLE_ONE;
            wdog_hit = (idle_q == IDLE_LAST);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic [31:0] unused_to_w;
    assign unused_to_w = TO_W;
    assign wdog_hit    = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        src_d         = src_q;
        dst_d         = dst_q;
        status_d      = status_q;
        bus.cmd_ready = 1'b0;
        bus.m_reset   = 1'b0;
        bus.m_enable  = '0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;

        if (src_stb && (src_q != '1)) src_d = src_q + CNT_ONE;
        if (dst_stb && (dst_q != '1)) dst_d = dst_q + CNT_ONE;

        case (state_q)
            IDLE: begin
                // First cycle out of reset still presents reset values.
                if (hold_q) begin
                    bus.m_reset = 1'b1;
                end else begin
                    bus.cmd_ready = 1'b1;
                    if (bus.cmd_valid) begin
                        sel_d = cmd_sel;
                        src_d = '0;
                        dst_d = '0;
                        if (sel_onehot) begin
                            status_d = 2'd0;
                            state_d  = ARM;
                        end else begin
                            status_d = 2'd1;
                            state_d  = DONE;
                        end
                    end
                end
            end
            ARM: begin
                bus.m_reset = 1'b1;
                bus.busy    = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                bus.m_enable = sel_q;
                bus.busy     = 1'b1;
                if (end_hit) begin
                    state_d = FLUSH;
                end else if (wdog_hit) begin
                    state_d = ABORT;
                end
            end
            FLUSH: begin
                bus.m_enable = sel_q;
                bus.busy     = 1'b1;
                state_d      = DONE;
            end
            ABORT: begin
                bus.m_reset = 1'b1;
                bus.busy    = 1'b1;
                status_d    = 2'd2;
                state_d     = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q  <= IDLE;
            hold_q   <= 1'b1;
            sel_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            status_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            hold_q   <= 1'b0;
            sel_q    <= sel_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            status_q <= status_d;
        end
    end
endmodule

// File: tb/tb_mod_sched.sv
// Bench for mod_sched: directed vector table, reset/watchdog sequences, and randomized ops against a scoreboard model.
module tb_mod_sched;
    localparam int NENG  = 5;
    localparam int CNT_W = 24;
    localparam int TO_W  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mod_sched_if #(.NENG(NENG), .CNT_W(CNT_W)) bus ();

    mod_sched #(.NENG(NENG), .SEL_LSB(2), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] dc;
        int          end_at;
        logic [15:0] smask;
        logic [15:0] dmask;
        logic [1:0]  exp_st;
        int          exp_src;
        int          exp_dst;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] ctl();
        return {bus.m_reset, bus.m_enable, bus.m_src_getn, bus.m_dst_putn,
                bus.busy, bus.done, bus.cmd_ready};
    endfunction

    function automatic logic [10:0] ectl(input logic r, input logic [4:0] en, input logic g,
                                         input logic p, input logic b, input logic d, input logic rdy);
        return {r, en, g, p, b, d, rdy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic eng_idle();
        bus.eng_src_getn = '1;
        bus.eng_dst_putn = '1;
        bus.eng_endn     = '1;
    endtask

    // Selected engine follows the script; all others toggle at random.
    task automatic drive(input logic [4:0] sel, input logic s, input logic d, input logic e);
        logic [4:0] g, p, n;
        g = 5'($urandom);
        p = 5'($urandom);
        n = 5'($urandom);
        for (int i = 0; i < 5; i++) begin
            if (sel[i]) begin
                g[i] = !s;
                p[i] = !d;
                n[i] = !e;
            end
        end
        bus.eng_src_getn = g;
        bus.eng_dst_putn = p;
        bus.eng_endn     = n;
    endtask

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 10) begin
            tick();
            smp();
            w++;
        end
        chk({tag, " ready"}, 64'(bus.cmd_ready), 64'd1);
    endtask

    task automatic run_op(input logic [23:0] dc, input int end_at, input logic [15:0] sm,
                          input logic [15:0] dm, input logic [1:0] est, input int esrc,
                          input int edst, input string tag);
        logic [4:0] sel;
        sel = dc[6:2];
        wait_ready(tag);
        bus.cmd_valid = 1'b1;
        bus.cmd_dc    = dc;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_dc    = 24'($urandom);
        if (est == 2'd0) begin
            smp();
            chk({tag, " arm"}, 64'(ctl()), 64'(ectl(1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)));
            for (int k = 0; k <= end_at + 1; k++) begin
                tick();
                drive(sel, sm[k], dm[k], k == end_at);
                smp();
                chk({tag, " run"}, 64'(ctl()),
                    64'(ectl(1'b0, sel, !sm[k], !dm[k], 1'b1, 1'b0, 1'b0)));
            end
            tick();
            eng_idle();
            smp();
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (n > 0) begin
                    tick();
                    smp();
                end
                chk({tag, " nosel"}, 64'({bus.m_reset, bus.m_enable}), 64'd0);
                if (bus.done === 1'b1) break;
            end
        end
        chk({tag, " done"}, 64'({bus.done, bus.busy, bus.cmd_ready}), 64'(3'b100));
        chk({tag, " status"}, 64'(bus.status), 64'(est));
        chk({tag, " beats"}, {16'd0, bus.src_beats, bus.dst_beats}, {16'd0, 24'(esrc), 24'(edst)});
        tick();
        smp();
        chk({tag, " idle"}, 64'({bus.cmd_ready, bus.done, bus.src_beats, bus.dst_beats}),
            64'({1'b1, 1'b0, 24'(esrc), 24'(edst)}));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] dc;
        int          n;
        int          L, es, ed;
        logic [15:0] sm, dm;
        logic [1:0]  est;

        tbl[0] = '{24'h000010, 8, 16'h00FF, 16'h00FF, 2'd0, 8, 8};
        tbl[1] = '{24'h000060, 0, 16'h0000, 16'h0000, 2'd1, 0, 0};
        tbl[2] = '{24'h000000, 0, 16'h0000, 16'h0000, 2'd1, 0, 0};
        tbl[3] = '{24'h000008, 3, 16'h0000, 16'h001B, 2'd0, 0, 4};
        tbl[4] = '{24'h000004, 0, 16'h0003, 16'h0000, 2'd0, 2, 0};
        tbl[5] = '{24'hFF8043, 2, 16'h0005, 16'h0002, 2'd0, 2, 1};
        tbl[6] = '{24'h000020, 5, 16'h0015, 16'h002A, 2'd0, 3, 3};

        bus.cmd_valid = 1'b0;
        bus.cmd_dc    = '0;
        eng_idle();
        rst_n = 1'b0;
        repeat (3) tick();
        smp();
        chk("reset ctl", 64'(ctl()), 64'(ectl(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)));
        chk("reset regs", {14'd0, bus.status, bus.src_beats, bus.dst_beats}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        smp();
        chk("release ctl", 64'(ctl()), 64'(ectl(1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1)));

        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].dc, tbl[i].end_at, tbl[i].smask, tbl[i].dmask,
                   tbl[i].exp_st, tbl[i].exp_src, tbl[i].exp_dst, $sformatf("vec%0d", i));
        end

        // Reset pulse in the middle of RUN.
        wait_ready("mrst");
        bus.cmd_valid = 1'b1;
        bus.cmd_dc    = 24'h000010;
        tick();
        bus.cmd_valid = 1'b0;
        smp();
        tick();
        drive(5'b00100, 1'b1, 1'b0, 1'b0);
        smp();
        chk("mrst pop", 64'(bus.m_src_getn), 64'd0);
        tick();
        rst_n = 1'b0;
        smp();
        chk("mrst count", 64'(bus.src_beats), 64'd1);
        tick();
        rst_n = 1'b1;
        eng_idle();
        smp();
        chk("mrst ctl", 64'(ctl()), 64'(ectl(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)));
        chk("mrst regs", {16'd0, bus.src_beats, bus.dst_beats}, 64'd0);
        tick();
        smp();
        run_op(tbl[0].dc, tbl[0].end_at, tbl[0].smask, tbl[0].dmask,
               tbl[0].exp_st, tbl[0].exp_src, tbl[0].exp_dst, "postrst");

        // Stalled engine.
        wait_ready("wdog");
        bus.cmd_valid = 1'b1;
        bus.cmd_dc    = 24'h000008;
        tick();
        bus.cmd_valid = 1'b0;
        smp();
        chk("wdog arm", 64'(bus.m_reset), 64'd1);
`ifdef MOD_SCHED_WDOG_EN
        n = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            smp();
            if (bus.m_reset === 1'b1) break;
            n++;
        end
        chk("wdog cycles", 64'(n), 64'd15);
        chk("wdog abort", 64'({bus.m_reset, bus.m_enable}), 64'({1'b1, 5'd0}));
        tick();
        smp();
        chk("wdog done", 64'({bus.done, bus.status}), 64'({1'b1, 2'd2}));
`else
        n = 0;
        repeat (100) tick();
        smp();
        chk("nowdog busy", 64'({bus.busy, bus.m_enable, bus.m_reset}), 64'({1'b1, 5'b00010, 1'b0}));
        tick();
        drive(5'b00010, 1'b0, 1'b0, 1'b1);
        smp();
        tick();
        eng_idle();
        smp();
        tick();
        smp();
        chk("nowdog done", 64'({bus.done, bus.status}), 64'({1'b1, 2'd0}));
`endif
        tick();
        smp();

        for (int t = 0; t < 40; t++) begin
            dc = 24'($urandom);
            if ($urandom_range(0, 9) < 7) begin
                dc[6:2] = '0;
                dc[2 + $urandom_range(0, 4)] = 1'b1;
            end
            L  = int'($urandom_range(0, 12));
            sm = 16'($urandom);
            dm = 16'($urandom);
            es = 0;
            ed = 0;
            for (int k = 0; k <= L + 1; k++) begin
                es += int'(sm[k]);
                ed += int'(dm[k]);
            end
            if ($countones(dc[6:2]) == 1) begin
                est = 2'd0;
            end else begin
                est = 2'd1;
                es  = 0;
                ed  = 0;
            end
            run_op(dc, L, sm, dm, est, es, ed, $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
